icache_refill_responder: RTL

//  Memory-side responder for instruction-cache miss traffic. Accepts block-read requests (source, block address),

---
 rtl/icache_refill_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/icache_refill_responder.sv
// Memory-side refill responder: queues icache block-read misses, fetches each line word by word and returns it whole.
// Optional feature macro ICACHE_REFILL_ERR_EN adds bus_rerr_i / mem_rsp_d_error_o with a sticky per-line error flag.
module icache_refill_responder #(
  parameter int XLEN        = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int SRC_BITS    = 3,
  parameter int REQ_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req_valid_i,
  output logic                        mem_req_ready_o,
  input  logic [SRC_BITS-1:0]         mem_req_a_source_i,
  input  logic [XLEN-1:0]             mem_req_a_addr_i,
  output logic                        mem_rsp_valid_o,
  input  logic                        mem_rsp_ready_i,
  output logic [SRC_BITS-1:0]         mem_rsp_d_source_o,
  output logic [XLEN-1:0]             mem_rsp_d_addr_o,
  output logic [BLOCK_WORDS*XLEN-1:0] mem_rsp_d_data_o,
  output logic                        bus_rd_valid_o,
  input  logic                        bus_rd_ready_i,
  output logic [XLEN-1:0]             bus_rd_addr_o,
  input  logic                        bus_rdata_valid_i,
  input  logic [XLEN-1:0]             bus_rdata_i
`ifdef ICACHE_REFILL_ERR_EN
  ,
  input  logic                        bus_rerr_i,
  output logic                        mem_rsp_d_error_o
`endif
);

  localparam int PW   = $clog2(REQ_DEPTH);
  localparam int CW   = $clog2(BLOCK_WORDS) + 1;
  localparam int OFFW = $clog2(BLOCK_WORDS) + 2;
  localparam logic [CW-1:0]   BW_C       = CW'(BLOCK_WORDS);
  localparam logic [PW:0]     DEPTH_C    = (PW+1)'(REQ_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << OFFW;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  logic [SRC_BITS-1:0] q_src  [REQ_DEPTH];
  logic [XLEN-1:0]     q_addr [REQ_DEPTH];
  logic [PW-1:0]       wptr, rptr;
  logic [PW:0]         count;
  logic                empty, push, pop;

  state_t              state;
  logic [SRC_BITS-1:0] src_r;
  logic [XLEN-1:0]     base_r;
  logic [CW-1:0]       issue_cnt, ret_cnt;
  logic [XLEN-1:0]     word_r [BLOCK_WORDS];
  logic                rd_fire, rdata_take;

  assign empty           = (count == '0);
  assign mem_req_ready_o = (count != DEPTH_C);
  assign push            = mem_req_valid_i && mem_req_ready_o;
  // Head is consumed from IDLE, or straight out of RESP on fire so lines run back to back.
  assign pop             = !empty && ((state == IDLE) || ((state == RESP) && mem_rsp_ready_i));

  assign bus_rd_valid_o  = (state == FETCH) && (issue_cnt < BW_C);
  assign bus_rd_addr_o   = bus_rd_valid_o ? (base_r + (XLEN'(issue_cnt) << 2)) : '0;
  assign rd_fire         = bus_rd_valid_o && bus_rd_ready_i;
  assign rdata_take      = (state == FETCH) && bus_rdata_valid_i && (ret_cnt < BW_C);

  assign mem_rsp_valid_o    = (state == RESP);
  assign mem_rsp_d_source_o = src_r;
  assign mem_rsp_d_addr_o   = base_r;

  always_comb begin
    mem_rsp_d_data_o = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      mem_rsp_d_data_o[i*XLEN +: XLEN] = word_r[i];
    end
  end

  // Request queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        q_src[i]  <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        q_src[wptr]  <= mem_req_a_source_i;
        q_addr[wptr] <= mem_req_a_addr_i & ALIGN_MASK;
        wptr         <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ICACHE_REFILL_ERR_EN
  logic err_r;
  assign mem_rsp_d_error_o = err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (pop) begin
      err_r <= 1'b0;
    end else if (rdata_take) begin
      err_r <= err_r | bus_rerr_i;
    end
  end
`endif

  // Line fetch / response FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_r     <= '0;
      base_r    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        word_r[i] <= '0;
      end
    end else if (pop) begin
      state     <= FETCH;
      src_r     <= q_src[rptr];
      base_r    <= q_addr[rptr];
      issue_cnt <= '0;
      ret_cnt   <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        word_r[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (rd_fire) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (rdata_take) begin
            word_r[ret_cnt[CW-2:0]] <= bus_rdata_i;
            ret_cnt                 <= ret_cnt + 1'b1;
          end
          if ((ret_cnt == BW_C) || (rdata_take && (ret_cnt == BW_C - 1'b1))) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
